// File: rtl/spawn_tick_gen.sv
// Multi-channel programmable timebase: periodic square-wave/tick dividers and re-armable one-shots.
// Optional build macro SPAWN_SYNC_EN adds a sync_pulse input that phase-aligns all channels.
module spawn_tick_gen #(
    parameter int                CHANNELS      = 4,
    parameter int                CNT_W         = 24,
    parameter logic [CNT_W-1:0]  DEFAULT_LIMIT = 24'h2625A0,
    parameter int                CH_W          = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                c_e,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic [CHANNELS-1:0] mode,
`ifdef SPAWN_SYNC_EN
    input  logic                sync_pulse,
`endif
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_limit,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] wave
);

    typedef enum logic [1:0] {
        OS_IDLE,
        OS_RUN,
        OS_DONE
    } os_state_t;

    os_state_t           state_q [CHANNELS];
    os_state_t           state_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];
    logic [CNT_W-1:0]    limit_q [CHANNELS];
    logic [CNT_W-1:0]    limit_d [CHANNELS];
    logic [CHANNELS-1:0] tick_d;
    logic [CHANNELS-1:0] wave_d;
    logic [CHANNELS-1:0] ch_en_q;
    logic [CHANNELS-1:0] mode_q;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] arm;
    logic [CHANNELS-1:0] advance;
    logic [CHANNELS-1:0] at_term;
    logic                cfg_xfer;
    logic                sync_now;

`ifdef SPAWN_SYNC_EN
    assign sync_now = sync_pulse;
`else
    assign sync_now = 1'b0;
`endif

    assign cfg_xfer = cfg_valid & cfg_ready;

    // Per-channel qualifiers; a write to an out-of-range channel matches nothing and is dropped.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
        wr_hit  = '0;
        arm     = '0;
        advance = '0;
        at_term = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i]  = cfg_xfer && (cfg_ch == CH_W'(i));
            arm[i]     = mode[i] && ch_en[i] && !ch_en_q[i] && (state_q[i] != OS_RUN);
            advance[i] = c_e && ch_en[i] && (!mode[i] || (state_q[i] == OS_RUN));
            at_term[i] = advance[i] && (cnt_q[i] == limit_q[i]);
        end
    end

    // Next-state: sync > mode change > cfg write > arm > terminal count > plain advance.
    always_comb begin
        tick_d = '0;
        wave_d = wave;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]   = cnt_q[i];
            limit_d[i] = limit_q[i];
            state_d[i] = state_q[i];

            if (wr_hit[i])
                limit_d[i] = cfg_limit;

            if (sync_now) begin
                cnt_d[i]  = '0;
                wave_d[i] = 1'b0;
            end else if (mode[i] != mode_q[i]) begin
                cnt_d[i]   = '0;
                state_d[i] = OS_IDLE;
            end else if (wr_hit[i]) begin
                cnt_d[i] = '0;
                if (arm[i])
                    state_d[i] = OS_RUN;
            end else if (arm[i]) begin
                cnt_d[i]   = '0;
                state_d[i] = OS_RUN;
            end else if (at_term[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                if (mode[i])
                    state_d[i] = OS_DONE;
                else
                    wave_d[i] = ~wave[i];
            end else if (advance[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // One-shot state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++)
                state_q[i] <= OS_IDLE;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                state_q[i] <= state_d[i];
        end
    end

    // Datapath registers: counters, limits, outputs and edge/mode history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: limit is a small flop array, not a RAM, so it is reset like any other register.
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]   <= '0;
                limit_q[i] <= DEFAULT_LIMIT;
            end
            tick      <= '0;
            wave      <= '0;
            cfg_ready <= 1'b1;
            ch_en_q   <= '0;
            mode_q    <= mode;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]   <= cnt_d[i];
                limit_q[i] <= limit_d[i];
            end
            tick      <= tick_d;
            wave      <= wave_d;
            cfg_ready <= ~cfg_xfer;
            ch_en_q   <= ch_en;
            mode_q    <= mode;
        end
    end

endmodule

// File: tb/tb_spawn_tick_gen.sv
// Directed self-checking bench for spawn_tick_gen (3 channels, small default limit for visibility).
// Define SPAWN_SYNC_EN for both files to exercise the sync_pulse scenario.
module tb_spawn_tick_gen;

    localparam int CHANNELS = 3;
    localparam int CNT_W    = 24;
    localparam int CH_W     = 2;
    localparam logic [CNT_W-1:0] DEF_LIM = 24'd9;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                c_e;
    logic [CHANNELS-1:0] ch_en;
    logic [CHANNELS-1:0] mode;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    logic [CNT_W-1:0]    cfg_limit;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] wave;
`ifdef SPAWN_SYNC_EN
    logic                sync_pulse;
`endif

    int checks   = 0;
    int failures = 0;

    spawn_tick_gen #(
        .CHANNELS      (CHANNELS),
        .CNT_W         (CNT_W),
        .DEFAULT_LIMIT (DEF_LIM),
        .CH_W          (CH_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_e       (c_e),
        .ch_en     (ch_en),
        .mode      (mode),
`ifdef SPAWN_SYNC_EN
        .sync_pulse(sync_pulse),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_limit (cfg_limit),
        .tick      (tick),
        .wave      (wave)
    );

    always #5 clk = ~clk;

    // Reference for a periodic channel n advancing cycles after its counter was cleared (wave=0).
    function automatic logic [1:0] per_exp(input int n, input int lim);
        per_exp = {(n % (lim + 1)) == 0, ((n / (lim + 1)) % 2) == 1};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        c_e       = 1'b0;
        ch_en     = '0;
        cfg_valid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input int ch, input int lim);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_limit = CNT_W'(lim);
        cyc();
        cfg_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        mode = '0;
        do_reset();
        checks++;
        if ({tick, wave, cfg_ready} !== {3'b000, 3'b000, 1'b1}) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {tick, wave, cfg_ready}, 7'b0000001);
        end
        c_e   = 1'b1;
        ch_en = 3'b001;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            checks++;
            if ({tick[0], wave[0]} !== per_exp(n, 9)) begin
                failures++;
                $display("FAIL default_limit n=%0d got=%b exp=%b", n, {tick[0], wave[0]}, per_exp(n, 9));
            end
        end
    endtask

    task automatic test_periodic();
        mode = '0;
        do_reset();
        cfg_write(0, 3);
        c_e   = 1'b1;
        ch_en = 3'b001;
        for (int n = 1; n <= 24; n++) begin
            cyc();
            checks++;
            if ({tick[0], wave[0]} !== per_exp(n, 3)) begin
                failures++;
                $display("FAIL t1_periodic n=%0d got=%b exp=%b", n, {tick[0], wave[0]}, per_exp(n, 3));
            end
        end
    endtask

    task automatic test_limit_zero();
        mode = '0;
        do_reset();
        cfg_write(1, 0);
        c_e   = 1'b1;
        ch_en = 3'b010;
        for (int n = 1; n <= 8; n++) begin
            cyc();
            checks++;
            if ({tick[1], wave[1]} !== per_exp(n, 0)) begin
                failures++;
                $display("FAIL t2_limit0 n=%0d got=%b exp=%b", n, {tick[1], wave[1]}, per_exp(n, 0));
            end
        end
    endtask

    task automatic test_one_shot();
        mode = 3'b001;
        do_reset();
        cfg_write(0, 5);
        c_e = 1'b1;
        cyc();
        for (int pass = 0; pass < 2; pass++) begin
            ch_en = 3'b001;
            for (int k = 0; k <= 11; k++) begin
                cyc();
                checks++;
                if ({tick[0], wave[0]} !== {k == 6, 1'b0}) begin
                    failures++;
                    $display("FAIL t3_oneshot pass=%0d k=%0d got=%b exp=%b", pass, k, {tick[0], wave[0]}, {k == 6, 1'b0});
                end
            end
            ch_en = 3'b000;
            cyc();
            checks++;
            if (tick[0] !== 1'b0) begin
                failures++;
                $display("FAIL t3_disarmed pass=%0d got=%b exp=0", pass, tick[0]);
            end
        end
    endtask

    task automatic test_cfg_collision();
        logic [1:0] e2;
        mode = '0;
        do_reset();
        cfg_write(2, 3);
        c_e   = 1'b1;
        ch_en = 3'b101;
        for (int n = 1; n <= 20; n++) begin
            if (n == 4) begin
                cfg_valid = 1'b1;
                cfg_ch    = 2'd2;
                cfg_limit = 24'd7;
            end else if (n == 10) begin
                cfg_valid = 1'b1;
                cfg_ch    = 2'd3;
                cfg_limit = 24'd0;
            end
            cyc();
            e2 = (n <= 4) ? 2'b00 : per_exp(n - 4, 7);
            checks++;
            if ({tick[2], wave[2], tick[0], wave[0]} !== {e2, per_exp(n, 9)}) begin
                failures++;
                $display("FAIL t4_collision n=%0d got=%b exp=%b", n, {tick[2], wave[2], tick[0], wave[0]}, {e2, per_exp(n, 9)});
            end
            if (n == 4 || n == 10 || n == 5) begin
                checks++;
                if (cfg_ready !== (n == 5)) begin
                    failures++;
                    $display("FAIL t4_cfg_ready n=%0d got=%b exp=%b", n, cfg_ready, n == 5);
                end
            end
            cfg_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rdy;
        mode = '0;
        do_reset();
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_limit = 24'd1;
        cyc();
        rdy[0]    = cfg_ready;
        cfg_ch    = 2'd1;
        cfg_limit = 24'd2;
        cyc();
        rdy[1] = cfg_ready;
        cyc();
        rdy[2]    = cfg_ready;
        cfg_valid = 1'b0;
        cyc();
        rdy[3] = cfg_ready;
        checks++;
        if (rdy !== 4'b1010) begin
            failures++;
            $display("FAIL b2b_ready_seq got=%b exp=%b", rdy, 4'b1010);
        end
        c_e   = 1'b1;
        ch_en = 3'b011;
        for (int n = 1; n <= 12; n++) begin
            cyc();
            checks++;
            if ({tick[1], wave[1], tick[0], wave[0]} !== {per_exp(n, 2), per_exp(n, 1)}) begin
                failures++;
                $display("FAIL b2b_limits n=%0d got=%b exp=%b", n, {tick[1], wave[1], tick[0], wave[0]}, {per_exp(n, 2), per_exp(n, 1)});
            end
        end
    endtask

    task automatic test_gated_and_reset();
        logic [1:0] e;
        mode = '0;
        do_reset();
        cfg_write(0, 3);
        ch_en = 3'b001;
        for (int k = 1; k <= 26; k++) begin
            c_e = (k % 2) == 1;
            cyc();
            e = {(k % 8) == 7, (((k + 1) / 8) % 2) == 1};
            checks++;
            if ({tick[0], wave[0]} !== e) begin
                failures++;
                $display("FAIL t5_gated k=%0d got=%b exp=%b", k, {tick[0], wave[0]}, e);
            end
        end
        rst_n = 1'b0;
        c_e   = 1'b1;
        cyc();
        checks++;
        if ({tick, wave, cfg_ready} !== 7'b0000001) begin
            failures++;
            $display("FAIL t5_midreset got=%b exp=%b", {tick, wave, cfg_ready}, 7'b0000001);
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            checks++;
            if ({tick[0], wave[0]} !== per_exp(n, 9)) begin
                failures++;
                $display("FAIL t5_postreset n=%0d got=%b exp=%b", n, {tick[0], wave[0]}, per_exp(n, 9));
            end
        end
    endtask

    task automatic test_mode_change();
        mode = '0;
        do_reset();
        cfg_write(1, 3);
        c_e   = 1'b1;
        ch_en = 3'b010;
        for (int n = 1; n <= 6; n++)
            cyc();
        checks++;
        if ({tick[1], wave[1]} !== 2'b01) begin
            failures++;
            $display("FAIL mode_pre got=%b exp=01", {tick[1], wave[1]});
        end
        mode = 3'b010;
        for (int k = 0; k < 8; k++) begin
            cyc();
            checks++;
            if ({tick[1], wave[1]} !== 2'b01) begin
                failures++;
                $display("FAIL mode_idle k=%0d got=%b exp=01", k, {tick[1], wave[1]});
            end
        end
        ch_en = 3'b000;
        cyc();
        ch_en = 3'b010;
        for (int k = 0; k <= 7; k++) begin
            cyc();
            checks++;
            if ({tick[1], wave[1]} !== {k == 4, 1'b1}) begin
                failures++;
                $display("FAIL mode_rearm k=%0d got=%b exp=%b", k, {tick[1], wave[1]}, {k == 4, 1'b1});
            end
        end
    endtask

`ifdef SPAWN_SYNC_EN
    task automatic test_sync();
        mode = '0;
        do_reset();
        cfg_write(0, 2);
        cfg_write(1, 4);
        c_e   = 1'b1;
        ch_en = 3'b011;
        for (int n = 1; n <= 4; n++)
            cyc();
        sync_pulse = 1'b1;
        cyc();
        sync_pulse = 1'b0;
        checks++;
        if ({tick[1:0], wave[1:0]} !== 4'b0000) begin
            failures++;
            $display("FAIL t6_sync got=%b exp=0000", {tick[1:0], wave[1:0]});
        end
        for (int m = 1; m <= 10; m++) begin
            cyc();
            checks++;
            if ({tick[1], wave[1], tick[0], wave[0]} !== {per_exp(m, 4), per_exp(m, 2)}) begin
                failures++;
                $display("FAIL t6_after m=%0d got=%b exp=%b", m, {tick[1], wave[1], tick[0], wave[0]}, {per_exp(m, 4), per_exp(m, 2)});
            end
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        c_e       = 1'b0;
        ch_en     = '0;
        mode      = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_limit = '0;
`ifdef SPAWN_SYNC_EN
        sync_pulse = 1'b0;
`endif
        test_reset();
        test_periodic();
        test_limit_zero();
        test_one_shot();
        test_cfg_collision();
        test_back_to_back();
        test_gated_and_reset();
        test_mode_change();
`ifdef SPAWN_SYNC_EN
        test_sync();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
